arb_mem_port_ctrl: RTL and testbench
====================================

Name: arb_mem_port_ctrl

Overview:
Downstream consumer of the 3-way request arbiter. Presents requester valids to the arbiter as its reqs and latches the one-hot grant as the transaction owner. Forwards the owner's request message to a single shared memory port, then routes the memory response back to that owner. Holds ownership for one full request/response transaction, so the arbiter is consulted only when the port is idle.

Parameters:
p_num_reqs, 3, number of requesters; must match the arbiter's p_num_reqs
p_req_nbits, 32, request message width per requester
p_resp_nbits, 32, response message width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
in_req_val  input  p_num_reqs  per-requester request valid
in_req_rdy  output  p_num_reqs  per-requester accept strobe
in_req_msg  input  p_num_reqs*p_req_nbits  requester i message in bits [i*p_req_nbits +: p_req_nbits]
arb_reqs  output  p_num_reqs  drives arbiter reqs
arb_grants  input  p_num_reqs  arbiter grants; combinational from arb_reqs
mem_req_val  output  1  shared port request valid
mem_req_rdy  input  1  shared port request ready
mem_req_msg  output  p_req_nbits  latched owner request
mem_resp_val  input  1  memory response valid
mem_resp_rdy  output  1  memory response ready
mem_resp_msg  input  p_resp_nbits  memory response
out_resp_val  output  p_num_reqs  per-requester response valid; only the owner bit is ever set
out_resp_rdy  input  p_num_reqs  per-requester response ready
out_resp_msg  output  p_resp_nbits  latched response, shared by all requesters
owner  output  p_num_reqs  one-hot current owner; 0 when idle
txn_count  output  16  completed transactions, wraps 0xFFFF->0

Behaviour:
- States: IDLE, REQ, RESP_WAIT, RESP_SEND. 2-bit encoded state register.
- Reset values: state=IDLE, owner=0, req/resp message registers=0, txn_count=0. All val/rdy outputs are 0 in the reset cycle and the following IDLE cycle until the accept conditions hold.
- IDLE:
  - arb_reqs = in_req_val.
  - Grant is legal iff arb_grants is exactly one-hot AND (arb_grants & in_req_val) != 0.
  - On a legal grant, same cycle: in_req_rdy = arb_grants. On the edge: owner <= arb_grants, req_msg_reg <= owner's slice of in_req_msg, state -> REQ.
  - Illegal or zero grant: no accept, in_req_rdy=0, stay IDLE.
- REQ: arb_reqs=0, in_req_rdy=0, mem_req_val=1, mem_req_msg=req_msg_reg. On mem_req_rdy=1 -> RESP_WAIT. Otherwise hold; message stays stable.
- RESP_WAIT: mem_resp_rdy=1. On mem_resp_val=1: resp_msg_reg <= mem_resp_msg, state -> RESP_SEND. A response arriving during REQ is not accepted, because mem_resp_rdy=0 there.
- RESP_SEND: out_resp_val = owner, out_resp_msg = resp_msg_reg.
  - On (out_resp_rdy & owner) != 0: state -> IDLE, owner <= 0, txn_count <= txn_count+1.
  - Non-owner out_resp_rdy bits are ignored.
- Minimum latency: 4 cycles from accept (IDLE) to return to IDLE. Peak throughput: one transaction per 4 cycles. New arbitration occurs only in IDLE.
- arb_reqs, in_req_rdy, mem_req_val, mem_resp_rdy and out_resp_val are pure decodes of state/owner/inputs; no output is registered beyond the state.
- Reset asserted mid-transaction (any state): the transaction is abandoned. No response is delivered, owner=0, txn_count=0 next cycle. A response returned after reset is not accepted until RESP_WAIT.
- in_req_val deasserting after accept has no effect on the transaction in flight.

Test Plan:
- Reset then single request: in_req_val=3'b010, msg1=0xA5A5_0001, grants=010, mem rdy/val immediate, resp 0xDEAD_BEEF, out_resp_rdy=111 -> in_req_rdy=010 at cycle 0, mem_req_msg=0xA5A5_0001, out_resp_val=010 with 0xDEAD_BEEF at cycle 3, IDLE at cycle 4, txn_count=1.
- Backpressure: mem_req_rdy low 5 cycles, mem_resp_val delayed 3 cycles, out_resp_rdy low 2 cycles -> mem_req_msg and out_resp_msg stable throughout, arb_reqs=0 until IDLE, exactly one txn_count increment.
- Contention: in_req_val=111, arbiter grants 100 then 001 -> owner sequence 100 then 001, each receives only its own response, in_req_rdy never asserted for 010 while busy.
- Illegal grants: in_req_val=001 with grants=011, then with grants=010 -> no accept, state stays IDLE, owner=0.
- Reset in RESP_WAIT: mem_resp_val pulsed in the reset cycle -> next cycle state=IDLE, owner=0, out_resp_val=0, txn_count=0, mem_resp_rdy=0.
- Counter wrap: preload 0xFFFF transactions (or force) then complete one -> txn_count=0x0000.

Source files
------------

// File: rtl/arb_mem_port_ctrl.sv
// arb_mem_port_ctrl: owns one requester at a time on a shared memory port.
// Ownership is taken from the arbiter grant in IDLE and held until the
// owner's response has been delivered. Only the state, owner and message
// registers are sequential; every handshake output is decoded from them.
module arb_mem_port_ctrl #(
  parameter int p_num_reqs   = 3,
  parameter int p_req_nbits  = 32,
  parameter int p_resp_nbits = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs-1:0]             in_req_val,
  output logic [p_num_reqs-1:0]             in_req_rdy,
  input  logic [p_num_reqs*p_req_nbits-1:0] in_req_msg,
  output logic [p_num_reqs-1:0]             arb_reqs,
  input  logic [p_num_reqs-1:0]             arb_grants,
  output logic                              mem_req_val,
  input  logic                              mem_req_rdy,
  output logic [p_req_nbits-1:0]            mem_req_msg,
  input  logic                              mem_resp_val,
  output logic                              mem_resp_rdy,
  input  logic [p_resp_nbits-1:0]           mem_resp_msg,
  output logic [p_num_reqs-1:0]             out_resp_val,
  input  logic [p_num_reqs-1:0]             out_resp_rdy,
  output logic [p_resp_nbits-1:0]           out_resp_msg,
  output logic [p_num_reqs-1:0]             owner,
  output logic [15:0]                       txn_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    RESP_WAIT = 2'd2,
    RESP_SEND = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [p_num_reqs-1:0]   owner_q;
  logic [p_req_nbits-1:0]  req_msg_reg;
  logic [p_resp_nbits-1:0] resp_msg_reg;
  logic [15:0]             txn_count_q;

  logic                    grant_legal;
  logic                    accept;
  logic                    owner_done;
  logic [p_req_nbits-1:0]  grant_msg;

  // A grant is usable only when it names exactly one requester that is
  // actually asking; anything else from the arbiter is ignored.
  assign grant_legal = $onehot(arb_grants) && ((arb_grants & in_req_val) != '0);
  assign accept      = (state == IDLE) && grant_legal;
  assign owner_done  = (out_resp_rdy & owner_q) != '0;

  // Select the granted requester's message slice (grant is one-hot here).
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_msg = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (arb_grants[i]) grant_msg = in_req_msg[i*p_req_nbits +: p_req_nbits];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: each phase advances only on its own handshake.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (grant_legal)  state_next = REQ;
      REQ:       if (mem_req_rdy)  state_next = RESP_WAIT;
      RESP_WAIT: if (mem_resp_val) state_next = RESP_SEND;
      RESP_SEND: if (owner_done)   state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Handshake decodes from state, owner and inputs.
  always_comb begin
    arb_reqs     = '0;
    in_req_rdy   = '0;
    mem_req_val  = 1'b0;
    mem_resp_rdy = 1'b0;
    out_resp_val = '0;
    unique case (state)
      IDLE: begin
        arb_reqs   = in_req_val;
        in_req_rdy = accept ? arb_grants : '0;
      end
      REQ:       mem_req_val  = 1'b1;
      RESP_WAIT: mem_resp_rdy = 1'b1;
      RESP_SEND: out_resp_val = owner_q;
      default: ;
    endcase
  end

  // Ownership, latched messages and completed-transaction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= '0;
      req_msg_reg  <= '0;
      resp_msg_reg <= '0;
      txn_count_q  <= '0;
    end else begin
      if (accept) begin
        owner_q     <= arb_grants;
        req_msg_reg <= grant_msg;
      end
      if (state == RESP_WAIT && mem_resp_val) resp_msg_reg <= mem_resp_msg;
      if (state == RESP_SEND && owner_done) begin
        owner_q     <= '0;
        txn_count_q <= txn_count_q + 16'd1;
      end
    end
  end

  assign mem_req_msg  = req_msg_reg;
  assign out_resp_msg = resp_msg_reg;
  assign owner        = owner_q;
  assign txn_count    = txn_count_q;

endmodule

// File: tb/tb_arb_mem_port_ctrl.sv
// tb_arb_mem_port_ctrl: directed and randomized transactions against a
// transaction-level expectation (who owns, which message, which response,
// how many completions), with handshake delays chosen per transaction.
module tb_arb_mem_port_ctrl;

  localparam int N = 3;
  localparam int W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_req_val;
  logic [N-1:0]    in_req_rdy;
  logic [N*W-1:0]  in_req_msg;
  logic [N-1:0]    arb_reqs;
  logic [N-1:0]    arb_grants;
  logic            mem_req_val;
  logic            mem_req_rdy;
  logic [W-1:0]    mem_req_msg;
  logic            mem_resp_val;
  logic            mem_resp_rdy;
  logic [W-1:0]    mem_resp_msg;
  logic [N-1:0]    out_resp_val;
  logic [N-1:0]    out_resp_rdy;
  logic [W-1:0]    out_resp_msg;
  logic [N-1:0]    owner;
  logic [15:0]     txn_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_count;

  arb_mem_port_ctrl #(.p_num_reqs(N), .p_req_nbits(W), .p_resp_nbits(W)) dut (
    .clk(clk), .reset(reset),
    .in_req_val(in_req_val), .in_req_rdy(in_req_rdy), .in_req_msg(in_req_msg),
    .arb_reqs(arb_reqs), .arb_grants(arb_grants),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .out_resp_val(out_resp_val), .out_resp_rdy(out_resp_rdy), .out_resp_msg(out_resp_msg),
    .owner(owner), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and land just after the edge, where inputs change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] m, input logic [N-1:0] g);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = m[i*W +: W];
    return r;
  endfunction

  function automatic logic [N-1:0] pick_grant(input logic [N-1:0] vals);
    int cnt = $countones(vals);
    int r   = $urandom_range(0, cnt - 1);
    for (int i = 0; i < N; i++) begin
      if (vals[i]) begin
        if (r == 0) return N'(1) << i;
        r--;
      end
    end
    return '0;
  endfunction

  // One full transaction from IDLE back to IDLE, with the given stall
  // lengths on the memory request, the memory response and the owner.
  task automatic do_txn(input logic [N-1:0] vals, input logic [N-1:0] gnt,
                        input logic [N*W-1:0] msgs, input int d_req,
                        input int d_resp, input int d_out, input logic [W-1:0] rdata);
    logic [W-1:0] exp_msg = slice_of(msgs, gnt);
    in_req_val   = vals;
    arb_grants   = gnt;
    in_req_msg   = msgs;
    mem_req_rdy  = 1'b0;
    mem_resp_val = 1'b0;
    out_resp_rdy = '0;
    #1;
    check("idle_arb_reqs", arb_reqs, vals);
    check("accept_rdy", in_req_rdy, gnt);
    check("idle_mem_req_val", mem_req_val, 0);
    tick();
    // Requester side churns freely; it must not disturb the transaction.
    in_req_val = N'($urandom);
    arb_grants = N'($urandom);
    in_req_msg = {$urandom, $urandom, $urandom};
    for (int k = 0; k < d_req; k++) begin
      mem_resp_val = 1'($urandom);
      #1;
      check("req_val_stall", mem_req_val, 1);
      check("req_msg_stall", mem_req_msg, exp_msg);
      check("req_arb_reqs", arb_reqs, 0);
      check("req_in_rdy", in_req_rdy, 0);
      check("req_resp_rdy", mem_resp_rdy, 0);
      tick();
    end
    mem_req_rdy  = 1'b1;
    mem_resp_val = 1'b0;
    #1;
    check("req_val", mem_req_val, 1);
    check("req_msg", mem_req_msg, exp_msg);
    check("req_owner", owner, gnt);
    tick();
    mem_req_rdy = 1'b0;
    for (int k = 0; k < d_resp; k++) begin
      mem_resp_msg = $urandom;
      #1;
      check("wait_resp_rdy", mem_resp_rdy, 1);
      check("wait_out_val", out_resp_val, 0);
      check("wait_arb_reqs", arb_reqs, 0);
      tick();
    end
    mem_resp_val = 1'b1;
    mem_resp_msg = rdata;
    #1;
    check("wait_resp_rdy", mem_resp_rdy, 1);
    tick();
    mem_resp_val = 1'b0;
    mem_resp_msg = $urandom;
    for (int k = 0; k < d_out; k++) begin
      out_resp_rdy = N'($urandom) & ~gnt;
      #1;
      check("send_val_stall", out_resp_val, gnt);
      check("send_msg_stall", out_resp_msg, rdata);
      check("send_resp_rdy", mem_resp_rdy, 0);
      tick();
    end
    out_resp_rdy = gnt | N'($urandom);
    #1;
    check("send_val", out_resp_val, gnt);
    check("send_msg", out_resp_msg, rdata);
    check("send_in_rdy", in_req_rdy, 0);
    tick();
    exp_count    = exp_count + 16'd1;
    out_resp_rdy = '0;
    in_req_val   = '0;
    arb_grants   = '0;
    #1;
    check("done_owner", owner, 0);
    check("done_count", txn_count, exp_count);
    check("done_out_val", out_resp_val, 0);
    check("done_mem_req_val", mem_req_val, 0);
  endtask

  // Present a grant that must be refused and confirm IDLE is kept.
  task automatic idle_reject(input logic [N-1:0] vals, input logic [N-1:0] gnt);
    in_req_val = vals;
    arb_grants = gnt;
    #1;
    check("rej_in_rdy", in_req_rdy, 0);
    check("rej_arb_reqs", arb_reqs, vals);
    tick();
    #1;
    check("rej_owner", owner, 0);
    check("rej_mem_req_val", mem_req_val, 0);
    check("rej_still_idle", arb_reqs, vals);
    in_req_val = '0;
    arb_grants = '0;
  endtask

  initial begin
    logic [N-1:0] v;
    reset        = 1'b1;
    in_req_val   = '0;
    in_req_msg   = '0;
    arb_grants   = '0;
    mem_req_rdy  = 1'b0;
    mem_resp_val = 1'b0;
    mem_resp_msg = '0;
    out_resp_rdy = '0;
    exp_count    = '0;
    tick();
    tick();
    check("rst_owner", owner, 0);
    check("rst_count", txn_count, 0);
    check("rst_mem_req_msg", mem_req_msg, 0);
    check("rst_out_resp_msg", out_resp_msg, 0);
    check("rst_valrdy", {in_req_rdy, mem_req_val, mem_resp_rdy, out_resp_val}, 0);
    reset = 1'b0;
    tick();
    check("idle_valrdy", {in_req_rdy, mem_req_val, mem_resp_rdy, out_resp_val, arb_reqs}, 0);

    // Single request with no stalls.
    do_txn(3'b010, 3'b010, {32'h1111_2222, 32'hA5A5_0001, 32'h3333_4444}, 0, 0, 0, 32'hDEAD_BEEF);
    // Backpressure on every handshake.
    do_txn(3'b010, 3'b010, {$urandom, $urandom, $urandom}, 5, 3, 2, 32'h0BAD_F00D);
    // Contention: all three asking, grants 100 then 001.
    do_txn(3'b111, 3'b100, {$urandom, $urandom, $urandom}, 1, 0, 1, 32'hC0DE_0004);
    do_txn(3'b111, 3'b001, {$urandom, $urandom, $urandom}, 0, 1, 0, 32'hC0DE_0001);
    // Illegal grants.
    idle_reject(3'b001, 3'b011);
    idle_reject(3'b001, 3'b010);
    idle_reject(3'b101, 3'b000);

    // Reset while waiting for the memory response.
    in_req_val = 3'b100;
    arb_grants = 3'b100;
    tick();
    in_req_val  = '0;
    arb_grants  = '0;
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy  = 1'b0;
    #1;
    check("pre_rst_wait", mem_resp_rdy, 1);
    reset        = 1'b1;
    mem_resp_val = 1'b1;
    mem_resp_msg = 32'hFEED_FACE;
    tick();
    reset     = 1'b0;
    exp_count = '0;
    #1;
    check("midrst_owner", owner, 0);
    check("midrst_out_val", out_resp_val, 0);
    check("midrst_count", txn_count, 0);
    check("midrst_resp_rdy", mem_resp_rdy, 0);
    tick();
    check("midrst_late_resp", {mem_resp_rdy, out_resp_val, owner}, 0);
    mem_resp_val = 1'b0;
    do_txn(3'b001, 3'b001, {$urandom, $urandom, $urandom}, 0, 0, 0, 32'h1234_5678);

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      v = N'($urandom_range(1, 7));
      do_txn(v, pick_grant(v), {$urandom, $urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Counter wrap: preload the count and complete one more.
    force dut.txn_count_q = 16'hFFFF;
    tick();
    release dut.txn_count_q;
    #1;
    check("wrap_preload", txn_count, 16'hFFFF);
    exp_count = 16'hFFFF;
    do_txn(3'b100, 3'b100, {$urandom, $urandom, $urandom}, 0, 0, 0, 32'hAAAA_5555);
    check("wrap_zero", txn_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
